// File: rtl/if_id_stage_buf.sv
// if_id_stage_buf: flow-controlled IF/ID pipeline register with a 2-entry
// skid buffer, branch/jump flush and registered MIPS R/I/J field decode.
// Optional feature macro: IF_ID_PERF_CNT_EN adds saturating stall/flush
// performance counters (ports stall_cnt, flush_cnt and parameter CNT_W).
module if_id_stage_buf #(
  parameter int unsigned PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
`ifdef IF_ID_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc4,
  input  logic            flush,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [PC_W-1:0] id_pc4,
  output logic [5:0]      id_opcode,
  output logic [4:0]      id_rs,
  output logic [4:0]      id_rt,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_shamt,
  output logic [5:0]      id_func,
  output logic [15:0]     id_imm,
  output logic [25:0]     id_addr
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // Occupancy encoded as {skid_valid, main_valid}; 2'b10 cannot be reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  state_e            r_state;
  logic [31:0]       r_main_instr;
  logic [PC_W-1:0]   r_main_pc4;
  logic [31:0]       r_skid_instr;
  logic [PC_W-1:0]   r_skid_pc4;

  logic              w_main_valid;
  logic              w_skid_valid;
  logic              w_accept;
  logic              w_consume;

  assign w_main_valid = r_state[0];
  assign w_skid_valid = r_state[1];

  // if_ready comes straight from the skid flag, so id_ready never reaches it.
  assign if_ready  = ~w_skid_valid;
  assign w_accept  = if_valid & if_ready;
  assign w_consume = w_main_valid & id_ready;

  // Head outputs are register-only; an empty stage shows a NOP with PC+4 of 0.
  assign id_valid  = w_main_valid;
  assign id_instr  = w_main_valid ? r_main_instr : NOP_INSTR;
  assign id_pc4    = w_main_valid ? r_main_pc4   : '0;

  assign id_opcode = id_instr[31:26];
  assign id_rs     = id_instr[25:21];
  assign id_rt     = id_instr[20:16];
  assign id_rd     = id_instr[15:11];
  assign id_shamt  = id_instr[10:6];
  assign id_func   = id_instr[5:0];
  assign id_imm    = id_instr[15:0];
  assign id_addr   = id_instr[25:0];

  // Occupancy FSM and payload moves; flush wins over every transfer and drops
  // any word offered in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_main_instr <= NOP_INSTR;
      r_main_pc4   <= '0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc4   <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_instr <= if_instr;
            r_main_pc4   <= if_pc4;
            r_state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_consume) begin
            r_main_instr <= if_instr;
            r_main_pc4   <= if_pc4;
          end else if (w_accept) begin
            r_skid_instr <= if_instr;
            r_skid_pc4   <= if_pc4;
            r_state      <= ST_FULL;
          end else if (w_consume) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_consume) begin
            r_main_instr <= r_skid_instr;
            r_main_pc4   <= r_skid_pc4;
            r_state      <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  // Saturating counters: decode back-pressure cycles and flushes that killed work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (w_main_valid && !id_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (w_main_valid || w_skid_valid) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage_buf.sv
// tb_if_id_stage_buf: directed bench for if_id_stage_buf with a queue model
// of the held words; also checks counters when IF_ID_PERF_CNT_EN is defined.
module tb_if_id_stage_buf;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_func;
  logic [15:0] id_imm;
  logic [25:0] id_addr;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  entry_t sb[$];
  int     total = 0;
  int     bad   = 0;

`ifdef IF_ID_PERF_CNT_EN
  logic [1:0] stall_cnt;
  logic [1:0] flush_cnt;
  int         mStall = 0;
  int         mFlush = 0;

  if_id_stage_buf #(.PC_W(32), .NOP_INSTR(32'h0), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc4(if_pc4), .flush(flush), .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_func(id_func), .id_imm(id_imm), .id_addr(id_addr),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
  if_id_stage_buf #(.PC_W(32), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc4(if_pc4), .flush(flush), .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_func(id_func), .id_imm(id_imm), .id_addr(id_addr));
`endif

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the head of the scoreboard queue.
  task automatic checkModel();
    logic [31:0] eInstr;
    logic [31:0] ePc4;
    eInstr = (sb.size() > 0) ? sb[0].instr : 32'h0;
    ePc4   = (sb.size() > 0) ? sb[0].pc4   : 32'h0;
    checkOutput("if_ready", {31'b0, if_ready}, {31'b0, sb.size() < 2});
    checkOutput("id_valid", {31'b0, id_valid}, {31'b0, sb.size() > 0});
    checkOutput("id_instr", id_instr, eInstr);
    checkOutput("id_pc4", id_pc4, ePc4);
    checkOutput("id_opcode", {26'b0, id_opcode}, {26'b0, eInstr[31:26]});
    checkOutput("id_rs", {27'b0, id_rs}, {27'b0, eInstr[25:21]});
    checkOutput("id_rt", {27'b0, id_rt}, {27'b0, eInstr[20:16]});
    checkOutput("id_rd", {27'b0, id_rd}, {27'b0, eInstr[15:11]});
    checkOutput("id_shamt", {27'b0, id_shamt}, {27'b0, eInstr[10:6]});
    checkOutput("id_func", {26'b0, id_func}, {26'b0, eInstr[5:0]});
    checkOutput("id_imm", {16'b0, id_imm}, {16'b0, eInstr[15:0]});
    checkOutput("id_addr", {6'b0, id_addr}, {6'b0, eInstr[25:0]});
`ifdef IF_ID_PERF_CNT_EN
    checkOutput("stall_cnt", {30'b0, stall_cnt}, mStall);
    checkOutput("flush_cnt", {30'b0, flush_cnt}, mFlush);
`endif
  endtask

  // Drive one cycle of inputs, update the model at the edge, check 1 unit later.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    bit doConsume;
    bit doAccept;
    if_valid = v;
    if_instr = ins;
    if_pc4   = pc;
    id_ready = rdy;
    flush    = fl;
    doConsume = (sb.size() > 0) && rdy;
    doAccept  = v && (sb.size() < 2);
`ifdef IF_ID_PERF_CNT_EN
    if ((sb.size() > 0) && !rdy && mStall < 3) mStall++;
    if (fl && (sb.size() > 0) && mFlush < 3) mFlush++;
`endif
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (doConsume) void'(sb.pop_front());
      if (doAccept) sb.push_back('{instr: ins, pc4: pc});
    end
    #1;
    checkModel();
  endtask

  initial begin
    rst_n    = 1'b0;
    if_valid = 1'b0;
    if_instr = 32'h0;
    if_pc4   = 32'h0;
    flush    = 1'b0;
    id_ready = 1'b0;

    // Reset values while held in reset.
    #12;
    checkOutput("rst_if_ready", {31'b0, if_ready}, 32'd1);
    checkOutput("rst_id_valid", {31'b0, id_valid}, 32'd0);
    checkOutput("rst_id_instr", id_instr, 32'h0);
    checkOutput("rst_id_pc4", id_pc4, 32'h0);
    rst_n = 1'b1;

    // Idle after release.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Streaming with decode always ready: lw then add.
    applyStimulus(1'b1, 32'h8C22_0004, 32'h04, 1'b1, 1'b0);
    checkOutput("lw_opcode", {26'b0, id_opcode}, 32'h23);
    checkOutput("lw_rs", {27'b0, id_rs}, 32'd1);
    checkOutput("lw_rt", {27'b0, id_rt}, 32'd2);
    checkOutput("lw_imm", {16'b0, id_imm}, 32'h0004);
    applyStimulus(1'b1, 32'h0043_0820, 32'h08, 1'b1, 1'b0);
    checkOutput("add_func", {26'b0, id_func}, 32'h20);
    checkOutput("add_rd", {27'b0, id_rd}, 32'd1);
    checkOutput("add_pc4", id_pc4, 32'h08);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Decode stalls 3 cycles while 3 words are offered; only 2 fit.
    applyStimulus(1'b1, 32'h2001_0001, 32'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h2002_0002, 32'h14, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h2003_0003, 32'h18, 1'b0, 1'b0);
    checkOutput("stall_if_ready", {31'b0, if_ready}, 32'd0);
    checkOutput("stall_head", id_instr, 32'h2001_0001);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("drain_second", id_instr, 32'h2002_0002);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("drain_empty", {31'b0, id_valid}, 32'd0);

    // Back-to-back with simultaneous accept and consume while a word is held.
    applyStimulus(1'b1, 32'h1000_0005, 32'h20, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0800_0100, 32'h24, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0000, 32'h28, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill to FULL, then flush together with an offered word.
    applyStimulus(1'b1, 32'hAAAA_0001, 32'h30, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBBBB_0002, 32'h34, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hCCCC_0003, 32'h38, 1'b0, 1'b1);
    checkOutput("flush_id_valid", {31'b0, id_valid}, 32'd0);
    checkOutput("flush_id_instr", id_instr, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush_no_ghost", {31'b0, id_valid}, 32'd0);

    // Asynchronous reset between edges while FULL.
    applyStimulus(1'b1, 32'hDEAD_0001, 32'h40, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_0002, 32'h44, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_id_valid", {31'b0, id_valid}, 32'd0);
    checkOutput("arst_if_ready", {31'b0, if_ready}, 32'd1);
    checkOutput("arst_id_instr", id_instr, 32'h0);
    sb.delete();
`ifdef IF_ID_PERF_CNT_EN
    mStall = 0;
    mFlush = 0;
`endif
    if_valid = 1'b1;
    if_instr = 32'hBEEF_0001;
    @(posedge clk);
    #3;
    if_valid = 1'b0;
    rst_n    = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("arst_no_stale", {31'b0, id_valid}, 32'd0);

    // Counter scenario: one word held through 5 stall cycles, then flushed.
    applyStimulus(1'b1, 32'h3C01_1234, 32'h50, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
`ifdef IF_ID_PERF_CNT_EN
    checkOutput("perf_stall_sat", {30'b0, stall_cnt}, 32'd3);
    checkOutput("perf_flush_one", {30'b0, flush_cnt}, 32'd1);
`endif
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_stage_buf.md
# if_id_stage_buf

Clocked, flow-controlled IF/ID pipeline stage for the MIPS pipeline: replaces the transparent field splitter between fetch and decode. It captures the fetched instruction and PC+4 on a valid/ready handshake, holds them through decode stalls using a 2-entry skid buffer, and supports branch/jump flush. Its registered outputs expose the MIPS R/I/J field decode to the ID stage.

## Interface
Parameters:
- PC_W, 32, width of the PC+4 path.
- NOP_INSTR, 32'h0000_0000, instruction word presented on id_instr while id_valid=0 (sll $0,$0,0).
- CNT_W, 16, width of the performance counters (only with IF_ID_PERF_CNT_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch offers a word.
- if_ready  out  1  stage can accept; registered; equals ~skid_valid.
- if_instr  in  32  fetched instruction.
- if_pc4  in  PC_W  PC+4 of the fetched instruction.
- flush  in  1  synchronous kill of all held entries (taken branch/jump).
- id_ready  in  1  decode consumes this cycle.
- id_valid  out  1  head entry valid.
- id_instr  out  32  head instruction, or NOP_INSTR when invalid.
- id_pc4  out  PC_W  head PC+4, or 0 when invalid.
- id_opcode  out  6  id_instr[31:26].
- id_rs, id_rt, id_rd, id_shamt  out  5 each  [25:21], [20:16], [15:11], [10:6].
- id_func  out  6  [5:0].
- id_imm  out  16  [15:0].
- id_addr  out  26  [25:0].
- stall_cnt, flush_cnt  out  CNT_W each  present only with IF_ID_PERF_CNT_EN.

## Operation
- Storage: head register (main_valid, main_instr, main_pc4) and skid register (skid_valid, skid_instr, skid_pc4).
- accept = if_valid & if_ready; consume = id_valid & id_ready.
- States, encoded by {skid_valid, main_valid}: EMPTY (00), ONE (01), FULL (11). State 10 is illegal and unreachable.
- EMPTY: accept -> load head -> ONE.
- ONE:
  - accept & consume -> load head with new word; stay ONE.
  - accept & !consume -> load skid -> FULL.
  - consume only -> EMPTY.
- FULL: if_ready=0, so no accept. consume -> skid moves to head, skid cleared -> ONE.
- flush: highest priority. Clears main_valid and skid_valid -> EMPTY. A word offered in the same cycle is dropped, even though if_ready was 1. A consume in the same cycle still counts as completed for decode.
- Decoded fields are pure slices of id_instr, so they read as NOP fields when invalid.
- Payload registers load only on the transfers listed above; data is never reordered, duplicated or dropped except by flush.

## Timing
- Reset (async assert, sync release): main_valid=0, skid_valid=0, if_ready=1, id_valid=0, id_instr=NOP_INSTR, id_pc4=0, all fields from NOP_INSTR, counters=0.
- Latency: a word accepted on edge N appears on id_* after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle with id_ready held high.
- if_ready drops the cycle after the skid fills. No combinational path from id_ready to if_ready.
- id_* depend only on registers; no input-to-output combinational path.
- Reset asserted mid-transfer: all entries discarded immediately, with no wait for a clock.

## Configuration
- IF_ID_PERF_CNT_EN defined:
  - stall_cnt increments each cycle with id_valid & !id_ready.
  - flush_cnt increments each cycle flush=1 while main_valid|skid_valid.
  - Both counters saturate at all-ones and clear on reset.
- IF_ID_PERF_CNT_EN undefined: counter ports and logic are absent; the rest of the behaviour is identical.

## Test plan
- Reset release, then idle -> if_ready=1, id_valid=0, id_instr=32'h0, id_pc4=0.
- Streaming with id_ready=1: 32'h8C220004 with pc4=0x04, then 0x00430820 with pc4=0x08 -> each appears one cycle later. Check id_opcode=6'h23, rs=1, rt=2, imm=16'h0004; then func=6'h20, rd=1.
- id_ready=0 for 3 cycles while 3 words are offered -> first 2 accepted, if_ready=0 afterwards. After id_ready=1, words exit in order with none lost.
- FULL state plus flush=1 together with if_valid=1 -> next cycle EMPTY, id_valid=0, id_instr=NOP_INSTR, incoming word absent from output.
- rst_n pulsed low asynchronously mid-stream (between edges) -> id_valid=0 and if_ready=1 immediately; no stale word after release.
- With IF_ID_PERF_CNT_EN and CNT_W=2: 5 stall cycles -> stall_cnt=3 (saturated); one flush of a non-empty stage -> flush_cnt=1.
